// File: rtl/up_down_mod_counter_pkg.sv
// Shared constants and parameter-legality helper for the modulo-N up/down counter.
package up_down_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic bit params_ok(input int width, input int modulus, input int step_w);
        return (width >= 2) && (modulus >= 2) &&
               (longint'(modulus) <= (longint'(1) << width)) &&
               (step_w >= 1) && (step_w <= width);
    endfunction

endpackage

// File: rtl/up_down_mod_counter_if.sv
// Control/status bundle of the modulo-N counter; Sat/Ovf exist only when
// UP_DOWN_MOD_COUNTER_SAT_EN is defined.
interface up_down_mod_counter_if #(
    parameter int WIDTH  = 11,
    parameter int STEP_W = 1
);
    logic              En;
    logic              D;
    logic [STEP_W-1:0] Step;
    logic              Load;
    logic [WIDTH-1:0]  LoadVal;
    logic [WIDTH-1:0]  Out;
    logic              Cout;
    logic              Bout;
    logic              Zero;
    logic              AtMax;
    logic              StepErr;
`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
    logic              Sat;
    logic              Ovf;
`endif

    modport master (
        output En, D, Step, Load, LoadVal,
`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
        output Sat,
        input  Ovf,
`endif
        input  Out, Cout, Bout, Zero, AtMax, StepErr
    );

    modport slave (
        input  En, D, Step, Load, LoadVal,
`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
        input  Sat,
        output Ovf,
`endif
        output Out, Cout, Bout, Zero, AtMax, StepErr
    );

endinterface

// File: rtl/up_down_mod_counter_mod_add_sub.sv
// Combinational modular add/subtract of a step against MODULUS, with wrap flag.
module mod_add_sub #(
    parameter int WIDTH   = 11,
    parameter int MODULUS = 2**WIDTH,
    parameter int STEP_W  = 1
) (
    input  logic [WIDTH-1:0]  i_val,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_up,
    output logic [WIDTH-1:0]  o_next,
    output logic              o_wrap,
    output logic              o_step_err
);
    localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);

    logic [WIDTH:0] w_val_x;
    logic [WIDTH:0] w_step_x;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff_wrap;

    // One extra bit so MODULUS == 2**WIDTH and val+step never overflow.
    assign w_val_x     = {1'b0, i_val};
    assign w_step_x    = (WIDTH+1)'(i_step);
    assign w_sum       = w_val_x + w_step_x;
    assign w_diff_wrap = w_val_x + MOD_X - w_step_x;

    always_comb begin
        o_step_err = (w_step_x >= MOD_X);
        o_wrap     = 1'b0;
        o_next     = i_val;
        if (i_up) begin
            o_wrap = (w_sum >= MOD_X);
            o_next = o_wrap ? WIDTH'(w_sum - MOD_X) : WIDTH'(w_sum);
        end else begin
            o_wrap = (w_val_x < w_step_x);
            o_next = o_wrap ? WIDTH'(w_diff_wrap) : WIDTH'(w_val_x - w_step_x);
        end
    end

endmodule

// File: rtl/up_down_mod_counter.sv
// Modulo-N up/down counter with programmable step, clamping load and ripple carry/borrow.
// Optional saturate mode with sticky Ovf when UP_DOWN_MOD_COUNTER_SAT_EN is defined.
module up_down_mod_counter
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH   = 11,
    parameter int MODULUS = 2**WIDTH,
    parameter int STEP_W  = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    up_down_mod_counter_if.slave  io_bus
);
    localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    if (!params_ok(WIDTH, MODULUS, STEP_W)) begin : g_param_check
        $error("up_down_mod_counter: illegal WIDTH/MODULUS/STEP_W combination");
    end

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_wrap;
    logic             w_step_err;
    logic             w_up;
    logic             w_active;
    logic             w_sat_mode;
    logic             w_emit;

    function automatic logic [WIDTH-1:0] sat_bound(input logic up);
        return up ? MAX_VAL : '0;
    endfunction

    mod_add_sub #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .STEP_W  (STEP_W)
    ) u_mod_add_sub (
        .i_val      (r_count),
        .i_step     (io_bus.Step),
        .i_up       (w_up),
        .o_next     (w_next),
        .o_wrap     (w_wrap),
        .o_step_err (w_step_err)
    );

    assign w_up       = (io_bus.D == DIR_UP);
    assign w_active   = io_bus.En && !io_bus.Load && !w_step_err;
    assign w_load_val = ({1'b0, io_bus.LoadVal} < MOD_X) ? io_bus.LoadVal : MAX_VAL;

`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
    logic r_ovf;

    assign w_sat_mode = io_bus.Sat;
    assign io_bus.Ovf = r_ovf;

    // Any wrap in saturate mode means the clamp threw away part of the step.
    always_ff @(posedge Clk) begin
        if (Rst || io_bus.Load) begin
            r_ovf <= 1'b0;
        end else if (w_active && w_wrap && io_bus.Sat) begin
            r_ovf <= 1'b1;
        end
    end
`else
    assign w_sat_mode = 1'b0;
`endif

    // Flags describe the transition the next edge performs, so cascades ripple in one cycle.
    assign w_emit         = w_active && w_wrap && !w_sat_mode;
    assign io_bus.Cout    = w_emit && w_up;
    assign io_bus.Bout    = w_emit && !w_up;
    assign io_bus.StepErr = io_bus.En && w_step_err;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_count <= '0;
        end else if (io_bus.Load) begin
            r_count <= w_load_val;
        end else if (w_active) begin
            r_count <= (w_wrap && w_sat_mode) ? sat_bound(w_up) : w_next;
        end
    end

    assign io_bus.Out   = r_count;
    assign io_bus.Zero  = (r_count == '0);
    assign io_bus.AtMax = (r_count == MAX_VAL);

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Bench for up_down_mod_counter: vector table, corner sequences, random run
// against an arithmetic model, second modulus, two-stage cascade, saturate build.
module tb_up_down_mod_counter;
    localparam int W  = 4;
    localparam int M  = 10;
    localparam int SW = 3;
    localparam int M6 = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    up_down_mod_counter_if #(.WIDTH(W), .STEP_W(SW)) bus  ();
    up_down_mod_counter_if #(.WIDTH(W), .STEP_W(SW)) bus6 ();
    up_down_mod_counter_if #(.WIDTH(W), .STEP_W(SW)) bu   ();
    up_down_mod_counter_if #(.WIDTH(W), .STEP_W(SW)) bt   ();

    up_down_mod_counter #(.WIDTH(W), .MODULUS(M),  .STEP_W(SW)) dut   (.Clk(clk), .Rst(rst), .io_bus(bus));
    up_down_mod_counter #(.WIDTH(W), .MODULUS(M6), .STEP_W(SW)) dut6  (.Clk(clk), .Rst(rst), .io_bus(bus6));
    up_down_mod_counter #(.WIDTH(W), .MODULUS(M),  .STEP_W(SW)) units (.Clk(clk), .Rst(rst), .io_bus(bu));
    up_down_mod_counter #(.WIDTH(W), .MODULUS(M),  .STEP_W(SW)) tens  (.Clk(clk), .Rst(rst), .io_bus(bt));

    assign bt.En = bu.Cout | bu.Bout;

    typedef struct {
        bit ld; int lv; bit en; bit d; int st;
        int eo; bit ec; bit eb;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(bit ld, int lv, bit en, bit d, int st, int eo, bit ec, bit eb);
        vec_t v;
        v = '{ld, lv, en, d, st, eo, ec, eb};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(bit ld, int lv, bit en, bit d, int st);
        bus.Load    = ld;
        bus.LoadVal = 4'(lv);
        bus.En      = en;
        bus.D       = d;
        bus.Step    = 3'(st);
    endtask

    task automatic drive6(bit ld, int lv, bit en, bit d, int st);
        bus6.Load    = ld;
        bus6.LoadVal = 4'(lv);
        bus6.En      = en;
        bus6.D       = d;
        bus6.Step    = 3'(st);
    endtask

    task automatic edge_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mo, nx, ec, eb;
        bit ld, en, d, r;
        int lv, st;

        rst = 1'b1;
        drive(0, 0, 0, 1, 0);
        drive6(0, 0, 0, 1, 0);
        bu.En = 0; bu.D = 1; bu.Step = 3'd1; bu.Load = 0; bu.LoadVal = '0;
        bt.D = 1; bt.Step = 3'd1; bt.Load = 0; bt.LoadVal = '0;
`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
        bus.Sat = 0; bus6.Sat = 0; bu.Sat = 0; bt.Sat = 0;
`endif
        edge_cycle();
        rst = 1'b0;
        #1;
        chk("rst_out",   bus.Out, 0);
        chk("rst_zero",  bus.Zero, 1);
        chk("rst_atmax", bus.AtMax, 0);
        chk("rst_cout",  bus.Cout, 0);
        chk("rst_bout",  bus.Bout, 0);
        chk("rst_err",   bus.StepErr, 0);
`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
        chk("rst_ovf",   bus.Ovf, 0);
`endif
        @(negedge clk);

        // Vector table: expected flags are pre-edge, expected Out is post-edge.
        for (int i = 0; i < 10; i++) add(0, 0, 1, 1, 1, (i + 1) % 10, i == 9, 0);
        add(1, 2,  0, 0, 0, 2, 0, 0);
        add(0, 0,  1, 0, 3, 9, 0, 1);
        add(0, 0,  1, 0, 3, 6, 0, 0);
        add(1, 13, 1, 1, 1, 9, 0, 0);
        add(1, 3,  1, 1, 1, 3, 0, 0);
        add(0, 0,  1, 1, 0, 3, 0, 0);
        add(0, 0,  1, 1, 7, 0, 1, 0);
        add(0, 0,  1, 0, 7, 3, 0, 1);
        add(0, 0,  0, 1, 5, 3, 0, 0);
        add(1, 9,  0, 0, 0, 9, 0, 0);
        add(1, 10, 0, 0, 0, 9, 0, 0);
        add(1, 0,  0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].d, vecs[i].st);
            #1;
            chk($sformatf("vec%0d_cout", i), bus.Cout, vecs[i].ec);
            chk($sformatf("vec%0d_bout", i), bus.Bout, vecs[i].eb);
            chk($sformatf("vec%0d_err", i),  bus.StepErr, 0);
            edge_cycle();
            chk($sformatf("vec%0d_out", i),   bus.Out, vecs[i].eo);
            chk($sformatf("vec%0d_zero", i),  bus.Zero, vecs[i].eo == 0);
            chk($sformatf("vec%0d_atmax", i), bus.AtMax, vecs[i].eo == M - 1);
        end

        // Reset beats a simultaneous load and count.
        drive(1, 7, 0, 0, 0);
        edge_cycle();
        chk("preload_out", bus.Out, 7);
        rst = 1'b1;
        drive(1, 5, 1, 1, 1);
        edge_cycle();
        rst = 1'b0;
        chk("rst_over_load_out", bus.Out, 0);
        chk("rst_over_load_zero", bus.Zero, 1);
        drive(0, 0, 0, 1, 0);

        // Random run against plain modular arithmetic.
        mo = 0;
        for (int n = 0; n < 400; n++) begin
            ld = ($urandom_range(0, 7) == 0);
            lv = $urandom_range(0, 15);
            en = $urandom_range(0, 3) != 0;
            d  = $urandom_range(0, 1);
            st = $urandom_range(0, 7);
            r  = ($urandom_range(0, 39) == 0);
            rst = r;
            drive(ld, lv, en, d, st);
            #1;
            ec = 0; eb = 0; nx = mo;
            if (ld) begin
                nx = (lv < M) ? lv : M - 1;
            end else if (en && st < M) begin
                if (d) begin
                    ec = (mo + st >= M);
                    nx = (mo + st) % M;
                end else begin
                    eb = (mo < st);
                    nx = (((mo - st) % M) + M) % M;
                end
            end
            if (r) nx = 0;
            chk($sformatf("rnd%0d_cout", n), bus.Cout, ec);
            chk($sformatf("rnd%0d_bout", n), bus.Bout, eb);
            chk($sformatf("rnd%0d_err", n),  bus.StepErr, en && st >= M);
            edge_cycle();
            mo = nx;
            chk($sformatf("rnd%0d_out", n),   bus.Out, mo);
            chk($sformatf("rnd%0d_zero", n),  bus.Zero, mo == 0);
            chk($sformatf("rnd%0d_atmax", n), bus.AtMax, mo == M - 1);
        end
        rst = 1'b0;
        drive(0, 0, 0, 1, 0);

        // MODULUS=6 instance: illegal steps hold the count.
        drive6(1, 4, 0, 1, 0);
        edge_cycle();
        chk("m6_load", bus6.Out, 4);
        drive6(0, 0, 1, 1, 7);
        #1;
        chk("m6_err7", bus6.StepErr, 1);
        chk("m6_cout7", bus6.Cout, 0);
        edge_cycle();
        chk("m6_hold7", bus6.Out, 4);
        drive6(0, 0, 1, 1, 6);
        #1;
        chk("m6_err6", bus6.StepErr, 1);
        edge_cycle();
        chk("m6_hold6", bus6.Out, 4);
        drive6(0, 0, 1, 1, 5);
        #1;
        chk("m6_err5", bus6.StepErr, 0);
        chk("m6_cout5", bus6.Cout, 1);
        edge_cycle();
        chk("m6_wrap5", bus6.Out, 3);
        drive6(1, 13, 0, 1, 0);
        edge_cycle();
        chk("m6_clamp", bus6.Out, 5);
        chk("m6_atmax", bus6.AtMax, 1);
        drive6(0, 0, 1, 0, 6);
        #1;
        chk("m6_dn_err", bus6.StepErr, 1);
        chk("m6_dn_bout", bus6.Bout, 0);
        edge_cycle();
        chk("m6_dn_hold", bus6.Out, 5);
        drive6(0, 0, 0, 1, 0);

        // Units/tens cascade.
        rst = 1'b1;
        edge_cycle();
        rst = 1'b0;
        bu.En = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            #1;
            chk($sformatf("casc%0d_units", k), bu.Out, k % 10);
            chk($sformatf("casc%0d_tens", k),  bt.Out, (k / 10) % 10);
            chk($sformatf("casc%0d_ucout", k), bu.Cout, k % 10 == 9);
            chk($sformatf("casc%0d_tcout", k), bt.Cout, k % 100 == 99);
            if (k < 100) edge_cycle();
        end
        bu.En = 1'b0;
        @(negedge clk);

`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
        drive(1, 8, 0, 1, 0);
        edge_cycle();
        chk("sat_ovf_after_load", bus.Ovf, 0);
        bus.Sat = 1;
        drive(0, 0, 1, 1, 3);
        #1;
        chk("sat_up_cout", bus.Cout, 0);
        edge_cycle();
        chk("sat_up_out", bus.Out, 9);
        chk("sat_up_ovf", bus.Ovf, 1);
        drive(0, 0, 0, 1, 0);
        edge_cycle();
        edge_cycle();
        chk("sat_ovf_sticky", bus.Ovf, 1);
        bus.Sat = 0;
        drive(0, 0, 1, 1, 1);
        #1;
        chk("nosat_cout", bus.Cout, 1);
        edge_cycle();
        chk("nosat_out", bus.Out, 0);
        chk("nosat_ovf_hold", bus.Ovf, 1);
        drive(1, 5, 0, 1, 0);
        edge_cycle();
        chk("load_clears_ovf", bus.Ovf, 0);
        bus.Sat = 1;
        drive(0, 0, 1, 0, 7);
        #1;
        chk("sat_dn_bout", bus.Bout, 0);
        edge_cycle();
        chk("sat_dn_out", bus.Out, 0);
        chk("sat_dn_ovf", bus.Ovf, 1);
        drive(0, 0, 1, 1, 3);
        edge_cycle();
        chk("sat_noclamp_out", bus.Out, 3);
        chk("sat_noclamp_ovf", bus.Ovf, 1);
        drive(0, 0, 0, 1, 0);
        rst = 1'b1;
        edge_cycle();
        rst = 1'b0;
        chk("rst_clears_ovf", bus.Ovf, 0);
        bus.Sat = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/up_down_mod_counter.md
# up_down_mod_counter

Parametrised modulo-N up/down counter with programmable step, synchronous load and chainable carry/borrow outputs. It is the next generation of the queue's fixed-width binary up/down counter. It serves as the pointer and occupancy counter for non-power-of-two queue depths, and as a cascadable decade/prescaler stage. The count is held in a single register bank. Wrap arithmetic is modulo `MODULUS`, not modulo 2^`WIDTH`.

## Interface
Parameters:
- `WIDTH`, 11: count register width, ≥ 2.
- `MODULUS`, 2**WIDTH: count range is 0 … `MODULUS`-1; 2 ≤ `MODULUS` ≤ 2**`WIDTH`.
- `STEP_W`, 1: width of `Step`; 1 ≤ `STEP_W` ≤ `WIDTH`.

Ports:
- `Clk`, in, 1: single clock; all state updates on the rising edge.
- `Rst`, in, 1: reset, synchronous, active-high.
- `En`, in, 1: count enable.
- `D`, in, 1: direction; 1 = up, 0 = down.
- `Step`, in, `STEP_W`: increment/decrement magnitude.
- `Load`, in, 1: synchronous load strobe.
- `LoadVal`, in, `WIDTH`: value to load.
- `Out`, out, `WIDTH`: current count (registered).
- `Cout`, out, 1: carry; the up-step this cycle wraps past `MODULUS`-1.
- `Bout`, out, 1: borrow; the down-step this cycle wraps below 0.
- `Zero`, out, 1: `Out` == 0.
- `AtMax`, out, 1: `Out` == `MODULUS`-1.
- `StepErr`, out, 1: `Step` ≥ `MODULUS` while `En`=1.

## Operation
Per-edge priority is `Rst` > `Load` > `En`. Otherwise `Out` holds.
- **Rst**:
  - `Out` ← 0.
  - Sticky state (see Configuration) ← 0.
- **Load**:
  - `Out` ← `LoadVal` when `LoadVal` < `MODULUS`.
  - `Out` ← `MODULUS`-1 otherwise (clamp).
  - `En`/`D`/`Step` are ignored.
  - `Cout`/`Bout` are forced to 0 while `Load`=1.
- **Count up** (`En`=1, `D`=1), with s = `Step`:
  - Compute in `WIDTH`+1 bits.
  - If `Out`+s ≥ `MODULUS`: `Out` ← `Out`+s−`MODULUS` and `Cout`=1.
  - Else: `Out` ← `Out`+s.
- **Count down** (`En`=1, `D`=0):
  - If `Out` < s: `Out` ← `Out`+`MODULUS`−s and `Bout`=1.
  - Else: `Out` ← `Out`−s.
- **Step = 0** with `En`=1: `Out` holds; `Cout`=`Bout`=0.
- **Step ≥ `MODULUS`** with `En`=1:
  - Illegal.
  - `StepErr`=1, `Out` holds, `Cout`=`Bout`=0.
- **Cascading**: drive an upper stage's `En` with the lower stage's `Cout` | `Bout`, and share `D`. Upper stage `Step`=1.
- `Cout` and `Bout` are never asserted together.

## Timing
- `Out`:
  - Registered.
  - Reset value 0.
  - Reflects the effect of a cycle's inputs one edge later (latency 1).
- `Cout`, `Bout`, `StepErr`:
  - Combinational from the current `Out`, `En`, `D`, `Step`, `Load`.
  - They describe the transition that the next edge will perform, so a cascade completes in the same edge (ripple, no extra latency).
  - All are 0 during and after reset, given `En`=0.
- `Zero` and `AtMax` are combinational from `Out`. After reset `Zero`=1 and `AtMax`=0.
- `Rst` asserted mid-count: the next edge yields 0 regardless of `Load`/`En`.
- A `Load` and a count request in the same cycle: load wins, and no carry or borrow is emitted.

## Configuration
- Macro `UP_DOWN_MOD_COUNTER_SAT_EN`.
- **Defined**: adds input `Sat` (1) and output `Ovf` (1).
  - With `Sat`=1, up-counting clamps at `MODULUS`-1 and down-counting clamps at 0.
  - `Cout`/`Bout` stay 0 in saturate mode.
  - `Ovf` is a registered sticky flag. It is set on the edge at which a clamp discards any part of a step.
  - `Ovf` is cleared by `Rst` or `Load`. Reset value 0.
  - With `Sat`=0, behaviour is identical to the undefined build, and `Ovf` holds its value.
- **Undefined**: ports `Sat`/`Ovf` are absent and the counter always wraps.

## Structure
- Package `up_down_counter_pkg` contains:
  - Direction constants `DIR_UP`=1 and `DIR_DN`=0.
  - The parameter-legality check function (`MODULUS`, `STEP_W` ranges).
- Sub-module `mod_add_sub`:
  - Purely combinational modular add/subtract of `WIDTH`-bit operand and `STEP_W`-bit step against `MODULUS`.
  - Returns the next value plus wrap flag.
  - The top holds the register, the priority logic and the saturation option.

## Test plan
All items use `WIDTH`=4, `MODULUS`=10, `STEP_W`=3 unless stated.
1. Reset then count up: `Rst`=1 for 1 edge, then `En`=1, `D`=1, `Step`=1 for 10 edges.
   - `Out` 0→1…9→0.
   - `Cout`=1 only in the cycle `Out`=9.
   - `Zero`=1 at start and after the wrap.
2. Down wrap with step: `LoadVal`=2 loaded, then `D`=0, `Step`=3.
   - `Out` → 9 with `Bout`=1.
   - Next edge `Out` → 6 with `Bout`=0.
3. Load clamp and priority:
   - `Load`=1, `LoadVal`=13, `En`=1 → `Out`=9 and `Cout`=0.
   - `Rst`=1 with `Load`=1 → `Out`=0.
4. Illegal step: `Out`=4, `Step`=7 with `MODULUS`=6 (alternate build).
   - `StepErr`=1, `Out` stays 4, no carry.
5. Cascade: two instances (units/tens) counting up from 0.
   - After 99 edges the pair reads 9/9.
   - On edge 100 both read 0 and the tens `Cout` pulses in the preceding cycle.
6. `UP_DOWN_MOD_COUNTER_SAT_EN` build: `Sat`=1, `Out`=8, `Step`=3 up.
   - `Out`=9, `Ovf`=1, `Cout`=0.
   - `Ovf` stays 1 until `Load`, then reads 0.
